quad_bus_arbiter: RTL and testbench

- Sequences ownership of the shared 4-bit data bus among N_REQ tristate drivers.
- Each driver is a 4-bit tristate buffer whose output drives the bus when its enable is low.
- Grants one requester at a time with round-robin fairness and an optional tenure limit.
- Inserts a one-cycle all-released turnaround between owners so two drivers never overlap.
- Its oe_n outputs connect directly to the enable inputs of the bus's tristate buffers.

---
 rtl/nibbler_bus_pkg.sv | 27 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/quad_bus_arbiter.sv | 92 +++++++++
 tb/tb_quad_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_bus_pkg.sv
// Shared definitions for the nibble-bus arbitration slice.
//   state_t        : arbiter FSM encoding (IDLE, OWNED, TURN)
//   DEF_N_REQ      : default requester count
//   onehot_to_idx  : converts a one-hot vector (up to 8 bits) to an index
package nibbler_bus_pkg;

    localparam int DEF_N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Returns the index of the highest set bit; 0 for an all-zero vector.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oneHot);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oneHot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   lastIdx : index of the previous winner; search starts at lastIdx+1
//   valid   : high when any request bit is set
//   winner  : first requesting index at or after lastIdx+1, wrapping
module rr_pick
    import nibbler_bus_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] lastIdx,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    localparam int unsigned N_U = N_REQ;

    int unsigned       cand;
    logic [IDX_W-1:0]  candIdx;

    // Offsets 1..N_REQ visit every index once, ending on lastIdx itself,
    // so the previous winner is still eligible but has lowest priority.
    always_comb begin
        valid   = 1'b0;
        winner  = lastIdx;
        cand    = '0;
        candIdx = '0;
        for (int unsigned off = 1; off <= N_U; off++) begin
            cand    = (32'(lastIdx) + off) % N_U;
            candIdx = IDX_W'(cand);
            if (!valid && req[candIdx]) begin
                valid  = 1'b1;
                winner = candIdx;
            end
        end
    end

endmodule

// File: rtl/quad_bus_arbiter.sv
// Round-robin owner sequencer for a shared 4-bit tristate data bus.
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high
//   req      : level-sensitive per-requester bus requests
//   grant    : registered one-hot ownership
//   oe_n     : registered active-low tristate enables (always ~grant)
//   owner_id : index of the current or most recent owner
//   bus_busy : high while any grant bit is set
// Every owner change passes through a one-cycle all-released TURN state so
// two tristate drivers never overlap on the bus.
module quad_bus_arbiter
    import nibbler_bus_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int MAX_HOLD = 8,
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] oe_n,
    output logic [IDX_W-1:0] owner_id,
    output logic             bus_busy
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t            state;
    logic [HOLD_W-1:0] holdCnt;

    logic              pickValid;
    logic [IDX_W-1:0]  pickIdx;
    logic [N_REQ-1:0]  pickOneHot;
    logic              othersWaiting;
    logic              preempt;

    rr_pick #(.N_REQ(N_REQ)) picker (
        .req     (req),
        .lastIdx (owner_id),
        .valid   (pickValid),
        .winner  (pickIdx)
    );

    assign pickOneHot    = N_REQ'(1) << pickIdx;
    assign othersWaiting = |(req & ~grant);
    // A lone owner saturates holdCnt at MAX_HOLD, so ">=" lets a late
    // challenger preempt it on the very next edge.
    assign preempt       = (MAX_HOLD != 0) && (holdCnt >= HOLD_LAST) && othersWaiting;
    assign bus_busy      = |grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            oe_n     <= '1;
            owner_id <= IDX_W'(N_REQ - 1);
            holdCnt  <= '0;
        end else begin
            unique case (state)
                IDLE, TURN: begin
                    if (pickValid) begin
                        grant    <= pickOneHot;
                        oe_n     <= ~pickOneHot;
                        owner_id <= pickIdx;
                        holdCnt  <= '0;
                        state    <= OWNED;
                    end else begin
                        state    <= IDLE;
                    end
                end
                OWNED: begin
                    if (!req[owner_id] || preempt) begin
                        grant <= '0;
                        oe_n  <= '1;
                        state <= TURN;
                    end else if (holdCnt != HOLD_SAT) begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    oe_n  <= '1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_bus_arbiter.sv
module tb_quad_bus_arbiter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: MAX_HOLD = 8
    logic       rstA = 1'b1;
    logic [3:0] reqA = 4'b0000;
    logic [3:0] grantA, oeA;
    logic [1:0] ownerA;
    logic       busyA;

    // DUT B: MAX_HOLD = 3
    logic       rstB = 1'b1;
    logic [3:0] reqB = 4'b0000;
    logic [3:0] grantB, oeB;
    logic [1:0] ownerB;
    logic       busyB;

    int vectors = 0;
    int miscompares = 0;

    quad_bus_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dutA (
        .clk(clk), .reset(rstA), .req(reqA),
        .grant(grantA), .oe_n(oeA), .owner_id(ownerA), .bus_busy(busyA)
    );

    quad_bus_arbiter #(.N_REQ(4), .MAX_HOLD(3)) dutB (
        .clk(clk), .reset(rstB), .req(reqB),
        .grant(grantB), .oe_n(oeB), .owner_id(ownerB), .bus_busy(busyB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstA = 1'b1;
        reqA = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({grantA, oeA, busyA, ownerA} !== {4'b0000, 4'b1111, 1'b0, 2'd3}) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: grant=%b oe_n=%b busy=%b owner=%0d, want 0000 1111 0 3",
                         i, grantA, oeA, busyA, ownerA);
            end
        end
        rstA = 1'b0;
        tick();
        vectors++;
        if ({grantA, oeA, busyA, ownerA} !== {4'b0001, 4'b1110, 1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_first_grant: grant=%b oe_n=%b busy=%b owner=%0d, want 0001 1110 1 0",
                     grantA, oeA, busyA, ownerA);
        end
        reqA = 4'b0000;
        tick();
        vectors++;
        if ({grantA, oeA, busyA} !== {4'b0000, 4'b1111, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release_turn: grant=%b oe_n=%b busy=%b, want 0000 1111 0",
                     grantA, oeA, busyA);
        end
        tick();
    endtask

    task automatic test_single_latency();
        reqA = 4'b0100;
        tick();
        vectors++;
        if ({grantA, oeA, ownerA} !== {4'b0100, 4'b1011, 2'd2}) begin
            miscompares++;
            $display("FAIL single_grant: grant=%b oe_n=%b owner=%0d, want 0100 1011 2",
                     grantA, oeA, ownerA);
        end
        tick();
        vectors++;
        if (grantA !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_hold: grant=%b, want 0100", grantA);
        end
        reqA = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({grantA, oeA, ownerA} !== {4'b0000, 4'b1111, 2'd2}) begin
                miscompares++;
                $display("FAIL single_release[%0d]: grant=%b oe_n=%b owner=%0d, want 0000 1111 2",
                         i, grantA, oeA, ownerA);
            end
        end
    endtask

    task automatic test_handover();
        logic [3:0] expSeq [5];
        expSeq = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010};
        reqA = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) reqA = 4'b0010;
            tick();
            vectors++;
            if (grantA !== expSeq[i] || oeA !== ~expSeq[i] || $countones(~oeA) > 1) begin
                miscompares++;
                $display("FAIL handover[%0d]: grant=%b oe_n=%b, want grant %b oe_n %b",
                         i, grantA, oeA, expSeq[i], ~expSeq[i]);
            end
        end
        vectors++;
        if (ownerA !== 2'd1) begin
            miscompares++;
            $display("FAIL handover_owner: owner=%0d, want 1", ownerA);
        end
        reqA = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reacquire();
        reqA = 4'b0010;
        tick();
        reqA = 4'b0000;
        tick();
        reqA = 4'b0010;
        tick();
        vectors++;
        if ({grantA, ownerA} !== {4'b0010, 2'd1}) begin
            miscompares++;
            $display("FAIL reacquire_same: grant=%b owner=%0d, want 0010 1", grantA, ownerA);
        end
        reqA = 4'b0000;
        tick();
        reqA = 4'b1010;
        tick();
        vectors++;
        if ({grantA, ownerA} !== {4'b1000, 2'd3}) begin
            miscompares++;
            $display("FAIL reacquire_rr_order: grant=%b owner=%0d, want 1000 3", grantA, ownerA);
        end
        reqA = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        int owners [5];
        logic [3:0] exp;
        owners = '{0, 1, 2, 3, 0};
        rstA = 1'b1;
        reqA = 4'b1111;
        tick();
        rstA = 1'b0;
        for (int t = 0; t < 5; t++) begin
            exp = 4'b0001 << owners[t];
            for (int k = 0; k < 8; k++) begin
                tick();
                vectors++;
                if ({grantA, ownerA} !== {exp, 2'(owners[t])}) begin
                    miscompares++;
                    $display("FAIL rr_tenure[%0d][%0d]: grant=%b owner=%0d, want %b %0d",
                             t, k, grantA, ownerA, exp, owners[t]);
                end
            end
            if (t == 4) reqA = 4'b0000;
            tick();
            vectors++;
            if (grantA !== 4'b0000) begin
                miscompares++;
                $display("FAIL rr_turn[%0d]: grant=%b, want 0000", t, grantA);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        reqA = 4'b1000;
        tick();
        vectors++;
        if (grantA !== 4'b1000) begin
            miscompares++;
            $display("FAIL midreset_setup: grant=%b, want 1000", grantA);
        end
        rstA = 1'b1;
        tick();
        vectors++;
        if ({grantA, oeA, busyA, ownerA} !== {4'b0000, 4'b1111, 1'b0, 2'd3}) begin
            miscompares++;
            $display("FAIL midreset_release: grant=%b oe_n=%b busy=%b owner=%0d, want 0000 1111 0 3",
                     grantA, oeA, busyA, ownerA);
        end
        rstA = 1'b0;
        reqA = 4'b1001;
        tick();
        vectors++;
        if ({grantA, oeA, ownerA} !== {4'b0001, 4'b1110, 2'd0}) begin
            miscompares++;
            $display("FAIL midreset_regrant: grant=%b oe_n=%b owner=%0d, want 0001 1110 0",
                     grantA, oeA, ownerA);
        end
        reqA = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_preempt();
        int extra;
        rstB = 1'b0;
        reqB = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (grantB !== 4'b1000) begin
                miscompares++;
                $display("FAIL preempt_lone[%0d]: grant=%b, want 1000", i, grantB);
            end
        end
        reqB = 4'b1010;
        extra = 0;
        tick();
        while (grantB === 4'b1000 && extra < 3) begin
            extra++;
            tick();
        end
        vectors++;
        if (grantB !== 4'b0000) begin
            miscompares++;
            $display("FAIL preempt_release: grant=%b after %0d extra owned cycles, want 0000 within 3",
                     grantB, extra);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({grantB, ownerB} !== {4'b0010, 2'd1}) begin
                miscompares++;
                $display("FAIL preempt_newowner[%0d]: grant=%b owner=%0d, want 0010 1", k, grantB, ownerB);
            end
        end
        tick();
        vectors++;
        if (grantB !== 4'b0000) begin
            miscompares++;
            $display("FAIL preempt_turn2: grant=%b, want 0000", grantB);
        end
        tick();
        vectors++;
        if ({grantB, ownerB} !== {4'b1000, 2'd3}) begin
            miscompares++;
            $display("FAIL preempt_requeue: grant=%b owner=%0d, want 1000 3", grantB, ownerB);
        end
        reqB = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_handover();
        test_reacquire();
        test_round_robin();
        test_reset_mid();
        test_preempt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
